layer_data_stream_ram: RTL and testbench
========================================

# layer_data_stream_ram

Parametrised per-layer activation store for the DQN datapath: one synchronous RAM partitioned into NUM_LAYERS regions, random-access writes from the layer compute units, and a burst-read engine that streams an entire layer out over a valid/ready interface with backpressure. It sits between the forward-pass layer engines and the backprop/error units. It replaces single-access read/write per-layer storage with whole-layer streaming, range checking and write/read collision forwarding.

## Interface
- DATA_WIDTH, 32, activation word width
- NUM_LAYERS, 4, number of layer regions (input, hidden 1, hidden 2, output)
- LAYER_WIDTH, 2, layer index width, ≥ clog2(NUM_LAYERS)
- ADDR_WIDTH, 5, per-layer address width; region depth 2^ADDR_WIDTH
- LAYER_SIZES, {8'd3,8'd32,8'd32,8'd2}, packed 8-bit valid-node count per layer, layer 0 in LSBs; each 1..2^ADDR_WIDTH
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_wr_en  in  1  write strobe, always accepted
- i_wr_layer  in  LAYER_WIDTH  write layer
- i_wr_addr  in  ADDR_WIDTH  write node index
- i_wr_data  in  DATA_WIDTH  write word
- i_rd_start  in  1  start burst read (single-cycle pulse)
- i_rd_layer  in  LAYER_WIDTH  layer to stream
- o_rd_busy  out  1  burst in progress
- o_data_valid  out  1  stream word valid
- i_data_ready  in  1  consumer accepts word
- o_data_layer  out  LAYER_WIDTH  layer of current word
- o_data_addr  out  ADDR_WIDTH  node index of current word
- o_data  out  DATA_WIDTH  stream word
- o_data_last  out  1  current word is node LAYER_SIZES[layer]-1
- o_error  out  1  one-cycle pulse on any rejected request

## Operation
- Physical address = {layer, addr}; RAM depth NUM_LAYERS·2^ADDR_WIDTH; RAM contents not reset.
- Write: i_wr_en with layer < NUM_LAYERS and addr < LAYER_SIZES[layer] writes next edge; otherwise dropped, o_error pulses.
- FSM IDLE / BURST / DRAIN.
- IDLE: i_rd_start with valid layer → latch layer, issue counter = 0, o_rd_busy = 1, go BURST. Invalid layer → o_error, stay IDLE.
- BURST: issue one RAM read per cycle while output-buffer credit > 0 (entries held + reads in flight < 2); counter increments per issue; after issuing index size-1 go DRAIN.
- DRAIN: once final word (o_data_last) is accepted (valid & ready) → IDLE, o_rd_busy = 0 the following cycle.
- i_rd_start while not IDLE: ignored, o_error pulses, current burst unaffected.
- Collision: write and read issue to same physical address in same cycle → read returns i_wr_data (write-first forwarding). Writes to a layer mid-burst affect only not-yet-issued indices.
- Output: 2-entry FIFO; head drives o_data*/o_data_valid; word stable while valid & !ready.
- Simultaneous write and any read activity: both proceed, no stall.

## Timing
- Reset: o_rd_busy, o_data_valid, o_data_last, o_error, o_data_layer, o_data_addr, o_data all 0; FSM IDLE; FIFO empty; counters 0.
- Reset mid-burst: burst abandoned immediately, outputs to reset values.
- Start accepted at edge N → first read issued edge N+1 → o_data_valid high after edge N+2 (2-cycle latency).
- Ready held high: one word per cycle, no bubbles; full layer of S words completes in S+2 cycles from start.
- Ready low: at most 2 words buffered, issue stalls; ready re-asserted → resumes with no lost or duplicated words.
- o_error asserted for exactly the cycle after the offending request edge.

## Structure
- Shared package dqn_mem_pkg: layer index localparams (INPUT/HIDDEN1/HIDDEN2/OUTPUT), FSM state encoding, function layer_size(LAYER_SIZES, layer), clog2 function.
- Sub-module layer_data_skid_fifo: 2-entry valid/ready FIFO carrying {last, layer, addr, data}, with a credit count output used for issue throttling.
- RAM inferred as block RAM in the top module; single write port, single synchronous read port.

## Test plan
- Write 0x3F800000, 0x40000000 to layer 0 addr 0,1; start layer 0, ready high → words at addr 0,1 back-to-back, last on addr 1, busy low 1 cycle after.
- Write addr 3 in layer 0 (size 2) → o_error pulse, subsequent burst of layer 0 shows addr 0,1 unchanged.
- Burst layer 1 (32 words, value = index), ready toggled 1-0-1 every cycle → 32 words in order, last on addr 31, no duplicates.
- Write addr 5 layer 2 with 0xDEADBEEF in the exact cycle addr 5 is issued → streamed word 5 = 0xDEADBEEF.
- i_rd_start during burst of layer 3 → o_error pulse, original burst completes with 3 words.
- rst_n low at word 10 of layer 1 burst → all outputs 0 asynchronously; new start after release streams from addr 0.

Source files
------------

// File: rtl/dqn_mem_pkg.sv
// dqn_mem_pkg
//   Shared definitions for the DQN activation memories:
//   - layer index names (input, two hidden layers, output)
//   - burst-read FSM state encoding
//   - layer_size(): 8-bit node count of a layer from a packed size table
//   - clog2(): constant-function ceiling log2
package dqn_mem_pkg;

  localparam int LAYER_INPUT   = 0;
  localparam int LAYER_HIDDEN1 = 1;
  localparam int LAYER_HIDDEN2 = 2;
  localparam int LAYER_OUTPUT  = 3;

  // Upper bound on layers a packed size table may describe.
  localparam int MAX_LAYERS = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

  // Layers beyond the table report size 0, so every address is out of range.
  function automatic logic [7:0] layer_size(input logic [8*MAX_LAYERS-1:0] sizes,
                                            input int unsigned layer);
    if (layer >= MAX_LAYERS) return 8'd0;
    return sizes[layer*8 +: 8];
  endfunction

endpackage

// File: rtl/layer_data_skid_fifo.sv
// layer_data_skid_fifo
//   Two-entry valid/ready FIFO holding {last, layer, addr, data} stream words.
//   Ports:
//     clk, rst_n            clock / async active-low reset
//     i_push, i_push_data   write side (producer never pushes without credit)
//     i_ready               consumer ready; head pops on o_valid & i_ready
//     o_valid, o_head       head entry
//     o_credit              free slots counting a pop happening this cycle
module layer_data_skid_fifo
  import dqn_mem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_credit
);

  logic [WIDTH-1:0] r_ent [2];
  logic             r_rptr;
  logic             r_wptr;
  logic [1:0]       r_count;
  logic             w_pop;

  assign o_valid  = (r_count != 2'd0);
  assign w_pop    = o_valid & i_ready;
  assign o_head   = r_ent[r_rptr];
  // A slot freed by this cycle's pop can be handed to a read issued now:
  // that read lands two edges later, after the pop has happened.
  assign o_credit = 2'd2 - r_count + {1'b0, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent[0] <= '0;
      r_ent[1] <= '0;
      r_rptr   <= 1'b0;
      r_wptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_ent[r_wptr] <= i_push_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/layer_data_stream_ram.sv
// layer_data_stream_ram
//   Per-layer activation store: one synchronous RAM split into NUM_LAYERS
//   regions of 2^ADDR_WIDTH words, random-access writes, and a burst engine
//   that streams a whole layer over valid/ready with backpressure.
//   Ports:
//     clk, rst_n                        clock / async active-low reset
//     i_wr_en/layer/addr/data           write port, range checked
//     i_rd_start, i_rd_layer            start a layer burst
//     o_rd_busy                         burst in progress
//     o_data_valid, i_data_ready        stream handshake
//     o_data_layer/addr, o_data, o_data_last  stream word
//     o_error                           one-cycle pulse on a rejected request
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no burst; accepts i_rd_start for a valid layer
//   ST_BURST | issuing one RAM read per cycle while the FIFO has credit
//   ST_DRAIN | all reads issued; waiting for the last word to be accepted
module layer_data_stream_ram
  import dqn_mem_pkg::*;
#(
  parameter int                      DATA_WIDTH  = 32,
  parameter int                      NUM_LAYERS  = 4,
  parameter int                      LAYER_WIDTH = 2,
  parameter int                      ADDR_WIDTH  = 5,
  parameter logic [8*NUM_LAYERS-1:0] LAYER_SIZES = {8'd3, 8'd32, 8'd32, 8'd2}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_en,
  input  logic [LAYER_WIDTH-1:0] i_wr_layer,
  input  logic [ADDR_WIDTH-1:0]  i_wr_addr,
  input  logic [DATA_WIDTH-1:0]  i_wr_data,
  input  logic                   i_rd_start,
  input  logic [LAYER_WIDTH-1:0] i_rd_layer,
  output logic                   o_rd_busy,
  output logic                   o_data_valid,
  input  logic                   i_data_ready,
  output logic [LAYER_WIDTH-1:0] o_data_layer,
  output logic [ADDR_WIDTH-1:0]  o_data_addr,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_data_last,
  output logic                   o_error
);

  localparam int DEPTH  = NUM_LAYERS * (2 ** ADDR_WIDTH);
  localparam int PA_W   = LAYER_WIDTH + ADDR_WIDTH;
  localparam int META_W = 1 + LAYER_WIDTH + ADDR_WIDTH;
  localparam int PLD_W  = META_W + DATA_WIDTH;
  localparam logic [8*MAX_LAYERS-1:0] SIZES_EXT = (8*MAX_LAYERS)'(LAYER_SIZES);

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  r_rd_data;
  logic [META_W-1:0]      r_rd_meta;
  logic                   r_rd_vld;
  logic [1:0]             r_state;
  logic [LAYER_WIDTH-1:0] r_layer;
  logic [ADDR_WIDTH-1:0]  r_cnt;
  logic                   r_error;

  logic [31:0]      w_wr_layer_ext;
  logic [31:0]      w_rd_layer_ext;
  logic             w_wr_ok;
  logic             w_wr_go;
  logic             w_wr_err;
  logic             w_rd_layer_ok;
  logic             w_start_err;
  logic [7:0]       w_size;
  logic             w_cnt_last;
  logic [1:0]       w_credit;
  logic             w_issue;
  logic             w_last_pop;
  logic [PA_W-1:0]  w_wr_paddr;
  logic [PA_W-1:0]  w_rd_paddr;
  logic [PLD_W-1:0] w_head;

  // Layer indices are widened so the range compare stays meaningful when
  // NUM_LAYERS fills the whole index space.
  assign w_wr_layer_ext = 32'(i_wr_layer);
  assign w_rd_layer_ext = 32'(i_rd_layer);

  assign w_wr_ok  = (w_wr_layer_ext < 32'(NUM_LAYERS)) &&
                    (32'(i_wr_addr) < 32'(layer_size(SIZES_EXT, w_wr_layer_ext)));
  assign w_wr_go  = i_wr_en & w_wr_ok;
  assign w_wr_err = i_wr_en & ~w_wr_ok;

  assign w_rd_layer_ok = (w_rd_layer_ext < 32'(NUM_LAYERS));
  assign w_start_err   = i_rd_start & ((r_state != ST_IDLE) | ~w_rd_layer_ok);

  assign w_size     = layer_size(SIZES_EXT, 32'(r_layer));
  assign w_cnt_last = (32'(r_cnt) == (32'(w_size) - 32'd1));
  // The in-flight read already owns one unit of credit.
  assign w_issue    = (r_state == ST_BURST) && (w_credit > {1'b0, r_rd_vld});
  assign w_last_pop = o_data_valid & i_data_ready & o_data_last;

  assign w_wr_paddr = {i_wr_layer, i_wr_addr};
  assign w_rd_paddr = {r_layer, r_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_layer <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_rd_start && w_rd_layer_ok) begin
            r_state <= ST_BURST;
            r_layer <= i_rd_layer;
            r_cnt   <= '0;
          end
        end
        ST_BURST: begin
          if (w_issue) begin
            if (w_cnt_last) r_state <= ST_DRAIN;
            else            r_cnt   <= r_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (w_last_pop) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Block RAM: one write port, one registered read port, write-first on
  // a same-address collision so a read never returns the stale word.
  always_ff @(posedge clk) begin
    if (w_wr_go) r_mem[w_wr_paddr] <= i_wr_data;
    if (w_issue) begin
      if (w_wr_go && (w_wr_paddr == w_rd_paddr)) r_rd_data <= i_wr_data;
      else                                       r_rd_data <= r_mem[w_rd_paddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_meta <= '0;
      r_error   <= 1'b0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) r_rd_meta <= {w_cnt_last, r_layer, r_cnt};
      r_error <= w_wr_err | w_start_err;
    end
  end

  layer_data_skid_fifo #(
    .WIDTH (PLD_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_rd_vld),
    .i_push_data ({r_rd_meta, r_rd_data}),
    .i_ready     (i_data_ready),
    .o_valid     (o_data_valid),
    .o_head      (w_head),
    .o_credit    (w_credit)
  );

  assign {o_data_last, o_data_layer, o_data_addr, o_data} = w_head;
  assign o_rd_busy = (r_state != ST_IDLE);
  assign o_error   = r_error;

endmodule

// File: tb/tb_layer_data_stream_ram.sv
module tb_layer_data_stream_ram;

  localparam int DW = 32;
  localparam int NL = 4;
  localparam int LW = 2;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          i_wr_en;
  logic [LW-1:0] i_wr_layer;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          i_rd_start;
  logic [LW-1:0] i_rd_layer;
  logic          o_rd_busy;
  logic          o_data_valid;
  logic          i_data_ready;
  logic [LW-1:0] o_data_layer;
  logic [AW-1:0] o_data_addr;
  logic [DW-1:0] o_data;
  logic          o_data_last;
  logic          o_error;

  int n_assert;
  int n_fail;

  // Reference store and node counts (layer 0 is the LSB byte of the size table).
  logic [31:0] model_mem [NL][32];
  int          model_size [NL];

  layer_data_stream_ram dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wr_en      (i_wr_en),
    .i_wr_layer   (i_wr_layer),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_rd_start   (i_rd_start),
    .i_rd_layer   (i_rd_layer),
    .o_rd_busy    (o_rd_busy),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
    .o_data_layer (o_data_layer),
    .o_data_addr  (o_data_addr),
    .o_data       (o_data),
    .o_data_last  (o_data_last),
    .o_error      (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int lay, input int addr, input logic [31:0] data);
    bit ok;
    ok = (lay < NL) && (addr < model_size[lay]);
    i_wr_en    = 1'b1;
    i_wr_layer = LW'(lay);
    i_wr_addr  = AW'(addr);
    i_wr_data  = data;
    step();
    i_wr_en = 1'b0;
    if (ok) model_mem[lay][addr] = data;
    check("wr_error", 64'(o_error), 64'(!ok));
  endtask

  task automatic fill_layer(input int lay, input bit rnd);
    for (int a = 0; a < model_size[lay]; a++)
      do_write(lay, a, rnd ? $urandom : 32'(a));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(o_rd_busy), 64'(0));
    check({tag, "_valid"}, 64'(o_data_valid), 64'(0));
    check({tag, "_last"},  64'(o_data_last), 64'(0));
    check({tag, "_err"},   64'(o_error), 64'(0));
    check({tag, "_layer"}, 64'(o_data_layer), 64'(0));
    check({tag, "_addr"},  64'(o_data_addr), 64'(0));
    check({tag, "_data"},  64'(o_data), 64'(0));
  endtask

  // rmode: 0 ready high, 1 ready toggles 1-0-1, 2 random ready.
  // coll_idx: write coll_data to that index in the cycle it is issued (rmode 0).
  // restart_at: pulse a second start in that cycle. abort_at: reset after that many words.
  task automatic stream(input int lay, input int rmode, input int coll_idx,
                        input logic [31:0] coll_data, input int restart_at, input int abort_at);
    int got;
    int cyc;
    bit done;
    bit rdy;
    bit acc;
    bit hold;
    bit exp_err;
    logic [63:0] held;
    int sz;
    sz   = model_size[lay];
    got  = 0;
    cyc  = 0;
    done = 0;
    hold = 0;
    held = '0;
    i_rd_layer = LW'(lay);
    i_rd_start = 1'b1;
    step();
    i_rd_start = 1'b0;
    check("busy_after_start", 64'(o_rd_busy), 64'(1));
    check("err_after_start", 64'(o_error), 64'(0));
    while (!done && cyc < 400) begin
      if (rmode == 0)      rdy = 1'b1;
      else if (rmode == 1) rdy = (cyc % 2 == 0);
      else                 rdy = 1'($urandom_range(0, 1));
      i_data_ready = rdy;
      if (cyc == coll_idx) begin
        i_wr_en    = 1'b1;
        i_wr_layer = LW'(lay);
        i_wr_addr  = AW'(coll_idx);
        i_wr_data  = coll_data;
        model_mem[lay][coll_idx] = coll_data;
      end
      if (cyc == restart_at) begin
        i_rd_start = 1'b1;
        i_rd_layer = LW'((lay + 1) % NL);
      end
      if (rmode == 0 && cyc <= 2)
        check("first_valid_latency", 64'(o_data_valid), 64'(cyc == 2));
      if (hold)
        check("held_word_stable",
              {29'(0), o_data_valid, o_data_last, o_data_layer, o_data_addr, o_data}, held);
      acc = o_data_valid && rdy;
      if (acc) begin
        check("word_data",  64'(o_data), 64'(model_mem[lay][got]));
        check("word_addr",  64'(o_data_addr), 64'(got));
        check("word_layer", 64'(o_data_layer), 64'(lay));
        check("word_last",  64'(o_data_last), 64'(got == sz - 1));
        check("busy_during", 64'(o_rd_busy), 64'(1));
      end
      hold = o_data_valid && !rdy;
      held = {29'(0), o_data_valid, o_data_last, o_data_layer, o_data_addr, o_data};
      exp_err = (cyc == restart_at);
      step();
      cyc++;
      i_wr_en    = 1'b0;
      i_rd_start = 1'b0;
      check("stream_error_pulse", 64'(o_error), 64'(exp_err));
      if (acc) begin
        got++;
        if (got == sz) done = 1;
        if (got == abort_at) begin
          rst_n = 1'b0;
          #1;
          check_all_zero("abort_reset");
          #2;
          rst_n = 1'b1;
          i_data_ready = 1'b0;
          return;
        end
      end
    end
    i_data_ready = 1'b0;
    check("burst_finished", 64'(done), 64'(1));
    check("word_count", 64'(got), 64'(sz));
    check("busy_low_after_last", 64'(o_rd_busy), 64'(0));
    check("valid_low_after_last", 64'(o_data_valid), 64'(0));
    if (rmode == 0) check("burst_cycles", 64'(cyc), 64'(sz + 2));
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    model_size   = '{2, 32, 32, 3};
    rst_n        = 1'b0;
    i_wr_en      = 1'b0;
    i_wr_layer   = '0;
    i_wr_addr    = '0;
    i_wr_data    = '0;
    i_rd_start   = 1'b0;
    i_rd_layer   = '0;
    i_data_ready = 1'b0;
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < 32; a++) model_mem[l][a] = '0;

    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check("idle_busy", 64'(o_rd_busy), 64'(0));

    do_write(0, 0, 32'h3F80_0000);
    do_write(0, 1, 32'h4000_0000);
    stream(0, 0, -1, '0, -1, -1);

    do_write(0, 3, 32'h1234_5678);
    do_write(3, 3, 32'h1111_2222);
    stream(0, 0, -1, '0, -1, -1);

    fill_layer(1, 0);
    stream(1, 1, -1, '0, -1, -1);

    fill_layer(2, 1);
    stream(2, 0, 5, 32'hDEAD_BEEF, -1, -1);

    fill_layer(3, 1);
    stream(3, 0, -1, '0, 1, -1);

    stream(1, 0, -1, '0, -1, 10);
    step();
    stream(1, 0, -1, '0, -1, -1);

    for (int it = 0; it < 6; it++) begin
      int lay;
      lay = $urandom_range(0, NL - 1);
      fill_layer(lay, 1);
      do_write(0, $urandom_range(2, 31), $urandom);
      do_write(3, $urandom_range(3, 31), $urandom);
      stream(lay, 2, -1, '0, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
